network_top: RTL and testbench

- Fixed-point two-layer MLP inference engine: IN_DIM signed inputs -> HIDDEN_SIZE ReLU neurons -> OUTPUT_SIZE linear logits -> argmax.
- Top of the accelerator datapath. Weights and biases arrive as parallel ports from the surrounding register or memory block.
- Produces a class index, a one-hot vector and the flattened hidden activations.

---
 rtl/nn_arch_pkg.sv | 40 ++++
 rtl/mac_unit.sv | 56 +++++
 rtl/network_top.sv | 177 +++++++++++++++++
 tb/tb_network_top.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_arch_pkg.sv
// Shared sizes, numeric types, FSM encoding and the saturation helper for the MLP engine.
package nn_arch_pkg;

  localparam int DATA_W      = 8;
  localparam int ACC_W       = 32;
  localparam int IN_DIM      = 64;
  localparam int HIDDEN_SIZE = 8;
  localparam int OUTPUT_SIZE = 10;

  localparam int CNT_W     = $clog2(IN_DIM);
  localparam int HID_IDX_W = $clog2(HIDDEN_SIZE);
  localparam int CLS_W     = 4;
  localparam int PROD_W    = ACC_W + DATA_W;
  localparam int SAT_W     = ACC_W + DATA_W + 1;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } nn_state_e;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp a wide signed intermediate into the accumulator range.
  function automatic acc_t sat_acc(input logic signed [SAT_W-1:0] v);
    if (v > SAT_W'(ACC_MAX)) begin
      return ACC_MAX;
    end else if (v < SAT_W'(ACC_MIN)) begin
      return ACC_MIN;
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_unit.sv
// One neuron accumulator: load a bias, then add w*x each enabled cycle.
// NN_SAT_EN selects saturating accumulation; otherwise the sum wraps.
module mac_unit
  import nn_arch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic acc_en,
  input  acc_t bias,
  input  data_t w,
  input  acc_t x,
  output acc_t acc_next
);

  acc_t acc_q;
  acc_t acc_d;
  acc_t sum;

`ifdef NN_SAT_EN
  logic signed [PROD_W-1:0] prod_full;
  logic signed [SAT_W-1:0]  sum_w;
  acc_t prod;

  assign prod_full = PROD_W'(w) * PROD_W'(x);
  assign prod      = sat_acc(SAT_W'(prod_full));
  assign sum_w     = SAT_W'(acc_q) + SAT_W'(prod);
  assign sum       = sat_acc(sum_w);
`else
  acc_t prod;

  assign prod = acc_t'(w) * x;
  assign sum  = acc_q + prod;
`endif

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = bias;
    end else if (acc_en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Exposes the value taken at the next edge; equals the held value when idle.
  assign acc_next = acc_d;

endmodule

// File: rtl/network_top.sv
// Two-layer fixed-point MLP: IN_DIM inputs -> HIDDEN_SIZE ReLU -> OUTPUT_SIZE logits -> argmax.
// Build option NN_SAT_EN makes every accumulate saturate instead of wrap.
module network_top
  import nn_arch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W*IN_DIM-1:0]      bus_in,
  input  data_t                         weight_h [HIDDEN_SIZE][IN_DIM],
  input  data_t                         weight_o [HIDDEN_SIZE][OUTPUT_SIZE],
  input  acc_t                          bias_h   [HIDDEN_SIZE],
  input  acc_t                          bias_o   [OUTPUT_SIZE],
  output logic [CLS_W-1:0]              class_idx,
  output logic [OUTPUT_SIZE-1:0]        one_out,
  output logic                          hidden_all_done,
  output logic [ACC_W*HIDDEN_SIZE-1:0]  hidden_out_flat,
  output logic                          output_done,
  output logic [1:0]                    state_dbg
);

  nn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t x_q [IN_DIM];
  data_t x_d [IN_DIM];
  acc_t  hidden_q [HIDDEN_SIZE];
  acc_t  hidden_d [HIDDEN_SIZE];
  logic [CLS_W-1:0]       class_q, class_d;
  logic [OUTPUT_SIZE-1:0] one_q, one_d;
  logic hid_done_q, hid_done_d;
  logic out_done_q, out_done_d;

  logic hid_load, hid_en, out_load, out_en;
  logic [HID_IDX_W-1:0] hid_sel;
  acc_t hid_next [HIDDEN_SIZE];
  acc_t out_next [OUTPUT_SIZE];

  logic [CLS_W-1:0]       best_idx;
  logic [OUTPUT_SIZE-1:0] best_onehot;
  acc_t                   best_val;

  assign hid_sel = cnt_q[HID_IDX_W-1:0];

  for (genvar h = 0; h < HIDDEN_SIZE; h++) begin : g_hid
    mac_unit u_mac (
      .clk      (clk),
      .rst      (rst),
      .load     (hid_load),
      .acc_en   (hid_en),
      .bias     (bias_h[h]),
      .w        (weight_h[h][cnt_q]),
      .x        (acc_t'(x_q[cnt_q])),
      .acc_next (hid_next[h])
    );
  end

  for (genvar k = 0; k < OUTPUT_SIZE; k++) begin : g_out
    mac_unit u_mac (
      .clk      (clk),
      .rst      (rst),
      .load     (out_load),
      .acc_en   (out_en),
      .bias     (bias_o[k]),
      .w        (weight_o[hid_sel][k]),
      .x        (hidden_q[hid_sel]),
      .acc_next (out_next[k])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = out_next[0];
    for (int k = 1; k < OUTPUT_SIZE; k++) begin
      if (out_next[k] > best_val) begin
        best_val = out_next[k];
        best_idx = CLS_W'(k);
      end
    end
    best_onehot = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      best_onehot[k] = (best_idx == CLS_W'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    hidden_d   = hidden_q;
    class_d    = class_q;
    one_d      = one_q;
    hid_done_d = 1'b0;
    out_done_d = 1'b0;
    hid_load   = 1'b0;
    hid_en     = 1'b0;
    out_load   = 1'b0;
    out_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int j = 0; j < IN_DIM; j++) begin
            x_d[j] = bus_in[j*DATA_W +: DATA_W];
          end
          hid_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HID;
        end
      end
      ST_HID: begin
        hid_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_DIM-1)) begin
          // ReLU is taken on the sum that includes this cycle's final product.
          for (int h = 0; h < HIDDEN_SIZE; h++) begin
            hidden_d[h] = hid_next[h][ACC_W-1] ? '0 : hid_next[h];
          end
          hid_done_d = 1'b1;
          out_load   = 1'b1;
          cnt_d      = '0;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        out_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HIDDEN_SIZE-1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        class_d    = best_idx;
        one_d      = best_onehot;
        out_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      class_q    <= '0;
      one_q      <= '0;
      hid_done_q <= 1'b0;
      out_done_q <= 1'b0;
      for (int j = 0; j < IN_DIM; j++) x_q[j] <= '0;
      for (int h = 0; h < HIDDEN_SIZE; h++) hidden_q[h] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      class_q    <= class_d;
      one_q      <= one_d;
      hid_done_q <= hid_done_d;
      out_done_q <= out_done_d;
      x_q        <= x_d;
      hidden_q   <= hidden_d;
    end
  end

  always_comb begin
    hidden_out_flat = '0;
    for (int h = 0; h < HIDDEN_SIZE; h++) begin
      hidden_out_flat[h*ACC_W +: ACC_W] = hidden_q[h];
    end
  end

  assign class_idx       = class_q;
  assign one_out         = one_q;
  assign hidden_all_done = hid_done_q;
  assign output_done     = out_done_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_network_top.sv
// Directed vector bench for network_top: table of patterns plus reset/busy-start sequences.
module tb_network_top;
  import nn_arch_pkg::*;

  localparam int HF_W  = ACC_W*HIDDEN_SIZE;
  localparam int BOUND = 90;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [DATA_W*IN_DIM-1:0]    bus_in;
  data_t                       weight_h [HIDDEN_SIZE][IN_DIM];
  data_t                       weight_o [HIDDEN_SIZE][OUTPUT_SIZE];
  acc_t                        bias_h   [HIDDEN_SIZE];
  acc_t                        bias_o   [OUTPUT_SIZE];
  logic [CLS_W-1:0]            class_idx;
  logic [OUTPUT_SIZE-1:0]      one_out;
  logic                        hidden_all_done;
  logic [HF_W-1:0]             hidden_out_flat;
  logic                        output_done;
  logic [1:0]                  state_dbg;

  int checks;
  int failures;

  typedef struct {
    int                     pat;
    logic [HF_W-1:0]        hid;
    logic [CLS_W-1:0]       cls;
    logic [OUTPUT_SIZE-1:0] one;
  } vec_t;

  vec_t vecs [7];

  network_top dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .bus_in          (bus_in),
    .weight_h        (weight_h),
    .weight_o        (weight_o),
    .bias_h          (bias_h),
    .bias_o          (bias_o),
    .class_idx       (class_idx),
    .one_out         (one_out),
    .hidden_all_done (hidden_all_done),
    .hidden_out_flat (hidden_out_flat),
    .output_done     (output_done),
    .state_dbg       (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [HF_W-1:0] got, input logic [HF_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [HF_W-1:0] hflat(input acc_t h0, input acc_t h1, input acc_t h2,
                                            input acc_t h3, input acc_t h4, input acc_t h5,
                                            input acc_t h6, input acc_t h7);
    return {h7, h6, h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic set_x(input int j, input int v);
    bus_in[j*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic set_pattern(input int p);
    bus_in = '0;
    for (int h = 0; h < HIDDEN_SIZE; h++) begin
      bias_h[h] = '0;
      for (int j = 0; j < IN_DIM; j++) weight_h[h][j] = data_t'(1);
      for (int k = 0; k < OUTPUT_SIZE; k++) weight_o[h][k] = data_t'(1);
    end
    for (int k = 0; k < OUTPUT_SIZE; k++) bias_o[k] = '0;
    case (p)
      0: for (int j = 0; j < IN_DIM; j++) set_x(j, 1);
      1: begin
        bias_h[0] = -5; bias_h[1] = 7;  bias_h[2] = -1; bias_h[3] = 3;
        bias_h[4] = 0;  bias_h[5] = 2;  bias_h[6] = -9; bias_h[7] = 4;
        bias_o[3] = 100;
      end
      2: begin
        for (int j = 0; j < IN_DIM; j++) begin
          set_x(j, 1);
          weight_h[0][j] = data_t'(-1);
        end
      end
      3: begin
        for (int j = 0; j < IN_DIM; j++) begin
          set_x(j, (j % 8) + 1);
          for (int h = 0; h < HIDDEN_SIZE; h++) weight_h[h][j] = data_t'(8 - (j % 8));
        end
        for (int h = 0; h < HIDDEN_SIZE; h++) begin
          bias_h[h] = acc_t'(10*h);
          for (int k = 0; k < OUTPUT_SIZE; k++) weight_o[h][k] = '0;
          weight_o[h][7] = data_t'(1);
          weight_o[h][2] = data_t'(-1);
        end
      end
      4, 5: begin
        for (int h = 0; h < HIDDEN_SIZE; h++)
          for (int k = 0; k < OUTPUT_SIZE; k++) weight_o[h][k] = '0;
        for (int k = 0; k < OUTPUT_SIZE; k++) bias_o[k] = -20;
        bias_o[0] = -10; bias_o[1] = -3; bias_o[2] = -7; bias_o[3] = -3;
        if (p == 4) bias_o[9] = 5;
      end
      6: begin
        for (int j = 0; j < IN_DIM; j++) set_x(j, 1);
        bias_h[0] = 32'sh7FFF_FFF0;
        for (int h = 0; h < HIDDEN_SIZE; h++)
          for (int k = 0; k < OUTPUT_SIZE; k++) weight_o[h][k] = (k == 0) ? data_t'(1) : data_t'(0);
        bias_o[0] = 32'sh7FFF_FFF0;
      end
      default: ;
    endcase
  endtask

  // Pulses start, then watches a bounded window; optionally fires a second start while busy.
  task automatic run_inf(input int busy_at,
                         output int hid_cyc, output int out_cyc,
                         output int hd_cnt, output int od_cnt,
                         output logic [HF_W-1:0] hid_got,
                         output logic [CLS_W-1:0] cls_got,
                         output logic [OUTPUT_SIZE-1:0] one_got);
    hid_cyc = -1; out_cyc = -1; hd_cnt = 0; od_cnt = 0;
    hid_got = '0; cls_got = '0; one_got = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      @(posedge clk);
      #1;
      if (hidden_all_done) begin
        hd_cnt++;
        hid_cyc = cyc;
        hid_got = hidden_out_flat;
      end
      if (output_done) begin
        od_cnt++;
        out_cyc = cyc;
        cls_got = class_idx;
        one_got = one_out;
      end
      start = (cyc == busy_at);
      if (cyc == busy_at) bus_in = '0;
    end
  endtask

  task automatic check_run(input string tag, input vec_t v, input int busy_at);
    int hid_cyc, out_cyc, hd_cnt, od_cnt;
    logic [HF_W-1:0] hid_got;
    logic [CLS_W-1:0] cls_got;
    logic [OUTPUT_SIZE-1:0] one_got;
    set_pattern(v.pat);
    run_inf(busy_at, hid_cyc, out_cyc, hd_cnt, od_cnt, hid_got, cls_got, one_got);
    check_val({tag, " hidden_done_cycle"}, HF_W'(hid_cyc), HF_W'(IN_DIM));
    check_val({tag, " output_done_cycle"}, HF_W'(out_cyc), HF_W'(IN_DIM + HIDDEN_SIZE + 1));
    check_val({tag, " hidden_done_pulses"}, HF_W'(hd_cnt), HF_W'(1));
    check_val({tag, " output_done_pulses"}, HF_W'(od_cnt), HF_W'(1));
    check_val({tag, " hidden_out_flat"}, hid_got, v.hid);
    check_val({tag, " class_idx"}, HF_W'(cls_got), HF_W'(v.cls));
    check_val({tag, " one_out"}, HF_W'(one_got), HF_W'(v.one));
    check_val({tag, " one_out_popcount"}, HF_W'($countones(one_got)), HF_W'(1));
  endtask

  initial begin
    int done_seen;
    checks = 0;
    failures = 0;

    vecs[0] = '{0, hflat(64, 64, 64, 64, 64, 64, 64, 64), 4'd0, 10'b0000000001};
    vecs[1] = '{1, hflat(0, 7, 0, 3, 0, 2, 0, 4), 4'd3, 10'b0000001000};
    vecs[2] = '{2, hflat(0, 64, 64, 64, 64, 64, 64, 64), 4'd0, 10'b0000000001};
    vecs[3] = '{3, hflat(960, 970, 980, 990, 1000, 1010, 1020, 1030), 4'd7, 10'b0010000000};
    vecs[4] = '{4, '0, 4'd9, 10'b1000000000};
    vecs[5] = '{5, '0, 4'd1, 10'b0000000010};
`ifdef NN_SAT_EN
    vecs[6] = '{6, hflat(32'sh7FFF_FFFF, 64, 64, 64, 64, 64, 64, 64), 4'd0, 10'b0000000001};
`else
    vecs[6] = '{6, hflat(0, 64, 64, 64, 64, 64, 64, 64), 4'd1, 10'b0000000010};
`endif

    rst = 1'b1;
    start = 1'b0;
    set_pattern(0);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset class_idx", HF_W'(class_idx), '0);
    check_val("reset one_out", HF_W'(one_out), '0);
    check_val("reset hidden_out_flat", hidden_out_flat, '0);
    check_val("reset done_flags", HF_W'({hidden_all_done, output_done}), '0);
    check_val("reset state", HF_W'(state_dbg), HF_W'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      check_run($sformatf("vec%0d", i), vecs[i], -1);
    end

    // Abort in the middle of the hidden phase.
    set_pattern(3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_val("midrst class_idx", HF_W'(class_idx), '0);
    check_val("midrst one_out", HF_W'(one_out), '0);
    check_val("midrst hidden_out_flat", hidden_out_flat, '0);
    check_val("midrst state", HF_W'(state_dbg), HF_W'(ST_IDLE));
    done_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk);
      #1;
      if (hidden_all_done || output_done) done_seen++;
    end
    check_val("midrst no_done_pulse", HF_W'(done_seen), '0);

    // A start during HID must be ignored; then a clean run must be correct.
    check_run("busy", vecs[0], 10);
    check_run("after_busy", vecs[2], -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
